tx_arq_controller: RTL and testbench



---
 rtl/lasernet_pkg.sv | 33 +++
 rtl/packet_checksum.sv | 32 +++
 rtl/tx_arq_controller.sv | 145 ++++++++++++++
 tb/tb_tx_arq_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lasernet_pkg.sv
// Shared lasernet definitions: packet geometry, header flag constants and the
// transmit controller state encoding.
package lasernet_pkg;

    localparam int PKT_W   = 224;
    localparam int WORD_W  = 32;
    localparam int N_WORDS = 7;
    localparam int N_HALF  = 14;

    localparam int W_PORTS   = 0;
    localparam int W_SEQ     = 1;
    localparam int W_ACK     = 2;
    localparam int W_CTRL    = 3;
    localparam int W_CSUM    = 4;
    localparam int W_DATA_HI = 5;
    localparam int W_DATA_LO = 6;

    localparam logic [8:0] FLAG_FIN = 9'h001;
    localparam logic [8:0] FLAG_SYN = 9'h002;
    localparam logic [8:0] FLAG_PSH = 9'h008;
    localparam logic [8:0] FLAG_ACK = 9'h010;

    localparam logic [3:0] DATA_OFFSET = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUILD   = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAITACK = 3'd3,
        ST_ERROR   = 3'd4
    } arq_state_t;

endpackage

// File: rtl/packet_checksum.sv
// Combinational 16-bit folded sum over the 14 halfwords of a lasernet packet.
// Shared by transmit (inverted into the checksum field) and receive checking.
module packet_checksum
    import lasernet_pkg::*;
(
    input  logic [PKT_W-1:0] i_packet,
    output logic [15:0]      o_sum
);

    logic [15:0] w_half [N_HALF];
    logic [31:0] w_acc;

    genvar gi;
    generate
        for (gi = 0; gi < N_HALF; gi++) begin : g_half
            assign w_half[gi] = i_packet[PKT_W-1-16*gi -: 16];
        end
    endgenerate

    // Two folds always suffice: 14 halfwords cannot carry past bit 19.
    always_comb begin
        w_acc = 32'h0;
        for (int i = 0; i < N_HALF; i++) begin
            w_acc = w_acc + {16'h0, w_half[i]};
        end
        w_acc = {16'h0, w_acc[31:16]} + {16'h0, w_acc[15:0]};
        w_acc = {16'h0, w_acc[31:16]} + {16'h0, w_acc[15:0]};
    end

    assign o_sum = w_acc[15:0];

endmodule

// File: rtl/tx_arq_controller.sv
// Stop-and-wait transmit controller: builds one packet per payload, sends it,
// and retransmits on timeout until ACKed or the retry budget runs out.
module tx_arq_controller
    import lasernet_pkg::*;
#(
    parameter int          TIMEOUT     = 1_000_000,
    parameter int          MAX_RETRIES = 4,
    parameter logic [15:0] SRC_PORT    = 16'h0000,
    parameter logic [15:0] DST_PORT    = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ISN,
    input  logic             data_valid,
    input  logic [63:0]      data,
    output logic             data_ready,
    input  logic [31:0]      local_ack,
    input  logic             rx_valid,
    input  logic [31:0]      rx_ack,
    input  logic [8:0]       rx_flags,
    input  logic             tx_ready,
    output logic             tx_start,
    output logic [PKT_W-1:0] tx_packet,
    output logic             sent_ok,
    output logic             link_error,
    output logic [3:0]       retry_count
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    localparam logic [3:0]  MAX_R    = 4'(MAX_RETRIES);
    localparam int          CSUM_MSB = (N_WORDS - W_CSUM) * WORD_W - 1;

    arq_state_t       r_state;
    logic [63:0]      r_data;
    logic [31:0]      r_seq;
    logic [31:0]      r_timer;
    logic [3:0]       r_retry;
    logic             r_tx_start;
    logic [PKT_W-1:0] r_tx_packet;
    logic             r_sent_ok;
    logic             r_link_error;

    logic [31:0]      w_word [N_WORDS];
    logic [PKT_W-1:0] w_pkt_raw;
    logic [PKT_W-1:0] w_pkt_final;
    logic [15:0]      w_fold;
    logic             w_ack_ok;
    logic             w_timeout;

    // Header assembled with a zero checksum field; the sum is patched in after.
    assign w_word[W_PORTS]   = {SRC_PORT, DST_PORT};
    assign w_word[W_SEQ]     = r_seq;
    assign w_word[W_ACK]     = local_ack;
    assign w_word[W_CTRL]    = {DATA_OFFSET, 3'b000, FLAG_ACK | FLAG_PSH, 16'h0000};
    assign w_word[W_CSUM]    = 32'h0;
    assign w_word[W_DATA_HI] = r_data[63:32];
    assign w_word[W_DATA_LO] = r_data[31:0];

    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi++) begin : g_word
            assign w_pkt_raw[(N_WORDS-1-gi)*WORD_W +: WORD_W] = w_word[gi];
        end
    endgenerate

    packet_checksum u_csum (
        .i_packet (w_pkt_raw),
        .o_sum    (w_fold)
    );

    assign w_pkt_final = {w_pkt_raw[PKT_W-1:CSUM_MSB+1], ~w_fold,
                          w_pkt_raw[CSUM_MSB-16:0]};

    assign w_ack_ok  = rx_valid && ((rx_flags & FLAG_ACK) != 9'h0) &&
                       (rx_ack == r_seq + 32'd1);
    assign w_timeout = (r_timer == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_data       <= 64'h0;
            r_seq        <= ISN + 32'd1;
            r_timer      <= 32'h0;
            r_retry      <= 4'h0;
            r_tx_start   <= 1'b0;
            r_tx_packet  <= '0;
            r_sent_ok    <= 1'b0;
            r_link_error <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_sent_ok  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (data_valid) begin
                        r_data  <= data;
                        r_state <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    r_tx_packet <= w_pkt_final;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    // Any ACK seen here is stale or early and is dropped.
                    if (tx_ready) begin
                        r_tx_start <= 1'b1;
                        r_timer    <= 32'h0;
                        r_state    <= ST_WAITACK;
                    end
                end
                ST_WAITACK: begin
                    r_timer <= r_timer + 32'd1;
                    if (w_ack_ok) begin
                        r_sent_ok <= 1'b1;
                        r_seq     <= r_seq + 32'd1;
                        r_retry   <= 4'h0;
                        r_state   <= ST_IDLE;
                    end else if (w_timeout) begin
                        if (r_retry < MAX_R) begin
                            r_retry <= r_retry + 4'd1;
                            r_state <= ST_SEND;
                        end else begin
                            r_link_error <= 1'b1;
                            r_state      <= ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    r_link_error <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_ready  = (r_state == ST_IDLE) && !reset;
    assign tx_start    = r_tx_start;
    assign tx_packet   = r_tx_packet;
    assign sent_ok     = r_sent_ok;
    assign link_error  = r_link_error;
    assign retry_count = r_retry;

endmodule

// File: tb/tb_tx_arq_controller.sv
// Directed and randomized bench for tx_arq_controller against a packet/ARQ
// reference model built from the header layout and retry rules.
module tb_tx_arq_controller;

    localparam int          T   = 16;
    localparam int          MR  = 2;
    localparam logic [15:0] SRC = 16'hC0DE;
    localparam logic [15:0] DST = 16'h0042;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  ISN;
    logic         data_valid;
    logic [63:0]  data;
    logic         data_ready;
    logic [31:0]  local_ack;
    logic         rx_valid;
    logic [31:0]  rx_ack;
    logic [8:0]   rx_flags;
    logic         tx_ready;
    logic         tx_start;
    logic [223:0] tx_packet;
    logic         sent_ok;
    logic         link_error;
    logic [3:0]   retry_count;

    always #5 clk = ~clk;

    tx_arq_controller #(
        .TIMEOUT     (T),
        .MAX_RETRIES (MR),
        .SRC_PORT    (SRC),
        .DST_PORT    (DST)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .ISN         (ISN),
        .data_valid  (data_valid),
        .data        (data),
        .data_ready  (data_ready),
        .local_ack   (local_ack),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .rx_flags    (rx_flags),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_packet   (tx_packet),
        .sent_ok     (sent_ok),
        .link_error  (link_error),
        .retry_count (retry_count)
    );

    int           checks   = 0;
    int           failures = 0;
    logic [31:0]  m_seq;
    int           m_retry;
    logic [223:0] exp_pkt;

    task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference packet: seven words, checksum = ~ (twice-folded halfword sum).
    function automatic logic [223:0] model_pkt(input logic [31:0] seq, input logic [31:0] lack,
                                               input logic [63:0] d);
        logic [31:0]  w [7];
        logic [31:0]  s;
        logic [223:0] p;
        w[0] = {SRC, DST};
        w[1] = seq;
        w[2] = lack;
        w[3] = 32'h7018_0000;
        w[4] = 32'h0;
        w[5] = d[63:32];
        w[6] = d[31:0];
        s = 32'h0;
        for (int i = 0; i < 7; i++) s = s + {16'h0, w[i][31:16]} + {16'h0, w[i][15:0]};
        s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
        s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
        w[4] = {~s[15:0], 16'h0000};
        p = '0;
        for (int i = 0; i < 7; i++) p = {p[191:0], w[i]};
        return p;
    endfunction

    // Receiver view: end-around carry sum of every halfword.
    function automatic logic [15:0] endaround(input logic [223:0] p);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < 14; i++) s = s + {16'h0, p[223-16*i -: 16]};
        while (s[31:16] != 16'h0) s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
        return s[15:0];
    endfunction

    task automatic do_reset(input logic [31:0] isn);
        reset = 1'b1;
        ISN = isn;
        data_valid = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick;
        chk("rst_data_ready", data_ready, 1'b0);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_sent_ok", sent_ok, 1'b0);
        chk("rst_link_error", link_error, 1'b0);
        chk("rst_retry", retry_count, 4'd0);
        chk("rst_tx_packet", tx_packet, 224'h0);
        tick;
        reset = 1'b0;
        ISN = $urandom;
        #1;
        chk("ready_after_reset", data_ready, 1'b1);
        m_seq = isn + 32'd1;
        m_retry = 0;
    endtask

    task automatic accept(input logic [63:0] d, input logic [31:0] lack);
        data = d;
        local_ack = lack;
        data_valid = 1'b1;
        tick;
        data_valid = 1'b0;
        data = {$urandom, $urandom};
    endtask

    // Counts edges from the accept edge to the first tx_start; tx_ready is
    // held low for 'delay' SEND-state edges. local_ack is scrambled after BUILD.
    task automatic wait_start(input int delay, output int cyc);
        cyc = 0;
        while (cyc < delay + 24) begin
            tx_ready = (cyc >= 1 + delay);
            tick;
            cyc++;
            if (cyc == 1) local_ack = $urandom;
            if (tx_start) break;
        end
        tx_ready = 1'b1;
    endtask

    task automatic ack_window(input int ack_j, input bit bad, output bit acked,
                              output int gap, output bit stray);
        acked = 1'b0;
        stray = 1'b0;
        gap = 0;
        for (int j = 0; j < T; j++) begin
            rx_valid = 1'b0;
            rx_ack = $urandom;
            rx_flags = 9'($urandom);
            if (j == ack_j) begin
                rx_valid = 1'b1;
                rx_ack = m_seq + 32'd1;
                rx_flags = 9'($urandom) | 9'h010;
            end else if (bad && ($urandom_range(0, 2) == 0)) begin
                rx_valid = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    rx_ack = m_seq;
                    rx_flags = 9'h010;
                end else begin
                    rx_ack = m_seq + 32'd1;
                    rx_flags = 9'($urandom) & ~9'h010;
                end
            end
            tick;
            gap++;
            rx_valid = 1'b0;
            if (tx_start) stray = 1'b1;
            if (j == ack_j) begin
                acked = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_payload(input logic [63:0] d, input logic [31:0] lack, input int delay,
                                input int nto, input int ack_j, input bit bad, input bit stale);
        int cyc;
        int gap;
        bit acked;
        bit stray;
        chk("ready_idle", data_ready, 1'b1);
        accept(d, lack);
        chk("ready_busy", data_ready, 1'b0);
        wait_start(delay, cyc);
        chk("start_latency", cyc, 2 + delay);
        exp_pkt = model_pkt(m_seq, lack, d);
        chk("packet", tx_packet, exp_pkt);
        chk("w1_seq", tx_packet[191:160], m_seq);
        chk("w3_ctrl", tx_packet[127:96], 32'h7018_0000);
        chk("endaround", endaround(tx_packet), 16'hFFFF);
        for (int r = 0; r <= nto; r++) begin
            ack_window((r == nto) ? ack_j : -1, bad, acked, gap, stray);
            chk("stray_start", stray, 1'b0);
            if (r < nto) begin
                m_retry++;
                chk("retry_count", retry_count, m_retry);
                chk("no_sent_on_timeout", sent_ok, 1'b0);
                tx_ready = 1'b1;
                if (stale) begin
                    rx_valid = 1'b1;
                    rx_ack = m_seq + 32'd1;
                    rx_flags = 9'h018;
                end
                tick;
                gap++;
                rx_valid = 1'b0;
                chk("retx_start", tx_start, 1'b1);
                chk("retx_gap", gap, T + 1);
                chk("send_ack_ignored", sent_ok, 1'b0);
                chk("retx_packet", tx_packet, exp_pkt);
            end
        end
        chk("sent_ok", sent_ok, 1'b1);
        chk("ready_after_ack", data_ready, 1'b1);
        chk("retry_cleared", retry_count, 4'd0);
        m_seq = m_seq + 32'd1;
        m_retry = 0;
        tick;
        chk("sent_ok_pulse", sent_ok, 1'b0);
    endtask

    task automatic fail_payload(input logic [63:0] d, input logic [31:0] lack);
        int cyc;
        int gap;
        int starts;
        bit acked;
        bit stray;
        accept(d, lack);
        wait_start(0, cyc);
        starts = tx_start ? 1 : 0;
        exp_pkt = model_pkt(m_seq, lack, d);
        chk("fail_packet", tx_packet, exp_pkt);
        for (int r = 0; r <= MR; r++) begin
            ack_window(-1, 1'b1, acked, gap, stray);
            chk("fail_stray", stray, 1'b0);
            if (r < MR) begin
                m_retry++;
                chk("fail_retry", retry_count, m_retry);
                tick;
                if (tx_start) starts++;
                chk("fail_retx_packet", tx_packet, exp_pkt);
            end
        end
        chk("fail_start_count", starts, MR + 1);
        chk("link_error", link_error, 1'b1);
        chk("error_not_ready", data_ready, 1'b0);
        chk("error_retry", retry_count, MR);
        data_valid = 1'b1;
        stray = 1'b0;
        repeat (10) begin
            rx_valid = 1'b1;
            rx_ack = m_seq + 32'd1;
            rx_flags = 9'h010;
            tick;
            if (tx_start || sent_ok) stray = 1'b1;
        end
        rx_valid = 1'b0;
        data_valid = 1'b0;
        chk("error_quiet", stray, 1'b0);
        chk("link_error_sticky", link_error, 1'b1);
        chk("error_still_not_ready", data_ready, 1'b0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        ISN = 32'h0;
        data_valid = 1'b0;
        data = 64'h0;
        local_ack = 32'h0;
        rx_valid = 1'b0;
        rx_ack = 32'h0;
        rx_flags = 9'h0;
        tx_ready = 1'b1;

        do_reset(32'h0);
        send_payload(64'h0, 32'h0, 0, 0, 3, 1'b0, 1'b0);
        send_payload(64'h0123_4567_89AB_CDEF, 32'h0000_0055, 0, 1, 5, 1'b0, 1'b0);
        send_payload({$urandom, $urandom}, $urandom, 5, 0, T - 1, 1'b0, 1'b0);
        send_payload({$urandom, $urandom}, $urandom, 0, 1, T - 1, 1'b1, 1'b0);
        send_payload({$urandom, $urandom}, $urandom, 2, 2, 0, 1'b1, 1'b1);

        fail_payload({$urandom, $urandom}, $urandom);

        do_reset(32'hFFFF_FFFE);
        send_payload(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 1'b0, 1'b0);
        chk("seq_wrapped", m_seq, 32'h0);
        send_payload({$urandom, $urandom}, $urandom, 1, 0, 2, 1'b0, 1'b0);

        // Reset while waiting for an ACK.
        accept({$urandom, $urandom}, $urandom);
        wait_start(0, cyc);
        repeat (4) tick;
        do_reset(32'h1234_5678);
        send_payload({$urandom, $urandom}, $urandom, 0, 0, 4, 1'b0, 1'b0);

        // Reset landing on the SEND edge must suppress tx_start.
        accept({$urandom, $urandom}, $urandom);
        tx_ready = 1'b0;
        tick;
        tx_ready = 1'b1;
        reset = 1'b1;
        tick;
        chk("no_start_in_reset", tx_start, 1'b0);
        do_reset(32'hA5A5_0000);
        send_payload({$urandom, $urandom}, $urandom, 0, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            int aj;
            aj = ($urandom_range(0, 3) == 0) ? T - 1 : int'($urandom_range(0, T - 1));
            send_payload({$urandom, $urandom}, $urandom, $urandom_range(0, 5),
                         $urandom_range(0, MR), aj, 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
